// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_RESPOND
  } state_e;

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
    return addr_w - 2 - word_w(line_words) - index_w(num_lines);
  endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays: one combinational read port, word write, tag/valid write, flush-all.
module icache_store
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int WORD_W  = 2,
  parameter int TAG_W   = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [WORD_W-1:0]  rd_word_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [WORD_W-1:0]  wr_word_i,
  input  logic [31:0]        wr_data_i,
  input  logic               tv_we_i,
  input  logic [INDEX_W-1:0] tv_index_i,
  input  logic [TAG_W-1:0]   tv_tag_i
);

  localparam int NUM_LINES  = 1 << INDEX_W;
  localparam int LINE_WORDS = 1 << WORD_W;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  // Flush beats the final-beat valid set, so a line filled during a flush ends invalid.
  always_ff @(posedge clk) begin
    if (rst)          valid_q <= '0;
    else if (flush_i) valid_q <= '0;
    else if (tv_we_i) valid_q[tv_index_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tv_we_i) tag_q[tv_index_i] <= tv_tag_i;
    if (wr_en_i) data_q[{wr_index_i, wr_word_i}] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[{rd_index_i, rd_word_i}];

endmodule

// File: rtl/icache_core.sv
// Direct-mapped read-only instruction cache: lookup, burst line refill, registered response.
// state      | meaning
// ST_IDLE    | waiting for P_strobe
// ST_LOOKUP  | tag compare; hit/write answers, miss starts a burst
// ST_REFILL  | collecting burst beats into the line
// ST_RESPOND | returning the requested word of the filled line
module icache_core
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              P_strobe,
  input  logic [ADDR_W-1:0] P_addr,
  input  logic              P_rw,
  output logic [31:0]       P_data,
  output logic              P_ready,
  input  logic              flush,
  output logic              M_req,
  output logic [ADDR_W-1:0] M_addr,
  input  logic [31:0]       M_data,
  input  logic              M_valid
);

  localparam int WORD_W  = word_w(LINE_WORDS);
  localparam int INDEX_W = index_w(NUM_LINES);
  localparam int TAG_W   = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int OFF_W   = WORD_W + 2;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                req_rw_q, req_rw_d;
  logic [WORD_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]         p_data_q, p_data_d;
  logic                p_ready_q, p_ready_d;
  logic                m_req_q, m_req_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;

  logic [WORD_W-1:0]   req_word;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_data;
  logic                wr_en, tv_we, hit;
  logic                unused_addr_lsb;

  assign req_word        = req_addr_q[2 +: WORD_W];
  assign req_index       = req_addr_q[OFF_W +: INDEX_W];
  assign req_tag         = req_addr_q[ADDR_W-1 -: TAG_W];
  assign hit             = rd_valid && (rd_tag == req_tag);
  assign unused_addr_lsb = ^req_addr_q[1:0];

  icache_store #(
    .INDEX_W(INDEX_W),
    .WORD_W (WORD_W),
    .TAG_W  (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .rd_index_i(req_index),
    .rd_word_i (req_word),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_index_i(req_index),
    .wr_word_i (beat_cnt_q),
    .wr_data_i (M_data),
    .tv_we_i   (tv_we),
    .tv_index_i(req_index),
    .tv_tag_i  (req_tag)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_rw_d   = req_rw_q;
    beat_cnt_d = beat_cnt_q;
    p_data_d   = p_data_q;
    p_ready_d  = 1'b0;
    m_req_d    = 1'b0;
    m_addr_d   = m_addr_q;
    wr_en      = 1'b0;
    tv_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (P_strobe) begin
          req_addr_d = P_addr;
          req_rw_d   = P_rw;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!req_rw_q) begin
          p_data_d  = 32'h0;
          p_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (hit) begin
          p_data_d  = rd_data;
          p_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          m_req_d    = 1'b1;
          m_addr_d   = {req_addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
          beat_cnt_d = '0;
          state_d    = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (M_valid) begin
          wr_en      = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            tv_we   = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        p_data_d  = rd_data;
        p_ready_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      req_rw_q   <= 1'b1;
      beat_cnt_q <= '0;
      p_data_q   <= NOP;
      p_ready_q  <= 1'b0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_rw_q   <= req_rw_d;
      beat_cnt_q <= beat_cnt_d;
      p_data_q   <= p_data_d;
      p_ready_q  <= p_ready_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
    end
  end

  assign P_data  = p_data_q;
  assign P_ready = p_ready_q;
  assign M_req   = m_req_q;
  assign M_addr  = m_addr_q;

endmodule

// File: tb/tb_icache_core.sv
// Bench for icache_core: directed scenarios plus random fetches against a line-presence model.
module tb_icache_core;

  logic        clk = 1'b0;
  logic        rst, P_strobe, P_rw, flush, M_valid;
  logic [31:0] P_addr, M_data, P_data, M_addr;
  logic        P_ready, M_req;

  int total = 0;
  int bad   = 0;

  // Model: memory contents plus which line each index currently holds.
  logic [31:0] ovr [logic [31:0]];
  bit          model_valid [64];
  logic [21:0] model_tag   [64];

  logic [31:0] o_data, o_maddr;
  int          o_ready_cyc, o_last_cyc, o_nreq;
  bit          o_exp_hit;

  icache_core dut (
    .clk     (clk),
    .rst     (rst),
    .P_strobe(P_strobe),
    .P_addr  (P_addr),
    .P_rw    (P_rw),
    .P_data  (P_data),
    .P_ready (P_ready),
    .flush   (flush),
    .M_req   (M_req),
    .M_addr  (M_addr),
    .M_data  (M_data),
    .M_valid (M_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (ovr.exists(w)) return ovr[w];
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endfunction

  // Issues one fetch and plays the memory side; records what the DUT did.
  task automatic run_fetch(input logic [31:0] addr, input logic rw, input int gap, input bit flush_last);
    int beat, wait_gap, idx;
    bit started;
    idx       = int'(addr[9:4]);
    o_exp_hit = model_valid[idx] && (model_tag[idx] == addr[31:10]);
    o_nreq = 0; o_ready_cyc = -1; o_last_cyc = -1; o_data = 32'hDEAD_BEEF; o_maddr = '0;
    started = 1'b0; beat = 0; wait_gap = 0;
    P_strobe = 1'b1; P_addr = addr; P_rw = rw;
    tick();
    P_strobe = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      M_valid = 1'b0; flush = 1'b0;
      if (P_ready) begin
        o_data = P_data; o_ready_cyc = cyc;
        break;
      end
      if (M_req) begin
        o_nreq++; o_maddr = M_addr; started = 1'b1;
      end
      if (started && beat < 4) begin
        if (wait_gap == 0) begin
          M_valid = 1'b1;
          M_data  = memval(o_maddr + (32'(beat) << 2));
          if (beat == 3) begin
            o_last_cyc = cyc;
            flush = flush_last;
          end
          beat++;
          wait_gap = gap;
        end else begin
          wait_gap--;
        end
      end
      tick();
    end
    M_valid = 1'b0; flush = 1'b0;
    if (rw && !o_exp_hit) begin
      if (flush_last) model_clear();
      else begin
        model_valid[idx] = 1'b1;
        model_tag[idx]   = addr[31:10];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_clear();
    total++; if (P_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", P_ready); end
    total++; if (P_data !== 32'h13) begin bad++; $display("FAIL reset_data: got %h want 00000013", P_data); end
    total++; if (M_req !== 1'b0) begin bad++; $display("FAIL reset_mreq: got %b want 0", M_req); end
    total++; if (M_addr !== 32'h0) begin bad++; $display("FAIL reset_maddr: got %h want 0", M_addr); end
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h0000_0100, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 1) begin bad++; $display("FAIL cold_nreq: got %0d want 1", o_nreq); end
    total++; if (o_maddr !== 32'h100) begin bad++; $display("FAIL cold_maddr: got %h want 00000100", o_maddr); end
    total++; if (o_ready_cyc - o_last_cyc !== 2) begin bad++; $display("FAIL cold_latency: got %0d want 2", o_ready_cyc - o_last_cyc); end
    total++; if (o_data !== 32'hA0) begin bad++; $display("FAIL cold_data: got %h want 000000a0", o_data); end
  endtask

  task automatic test_hit();
    run_fetch(32'h0000_010C, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 0) begin bad++; $display("FAIL hit_nreq: got %0d want 0", o_nreq); end
    total++; if (o_ready_cyc !== 2) begin bad++; $display("FAIL hit_latency: got %0d want 2", o_ready_cyc); end
    total++; if (o_data !== 32'hA3) begin bad++; $display("FAIL hit_data: got %h want 000000a3", o_data); end
    tick();
    total++; if (P_ready !== 1'b0 || P_data !== 32'hA3) begin bad++; $display("FAIL hit_hold: got ready=%b data=%h want ready=0 data=000000a3", P_ready, P_data); end
  endtask

  task automatic test_conflict();
    run_fetch(32'h0000_0500, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 1 || o_data !== memval(32'h500)) begin bad++; $display("FAIL conflict_fill: got nreq=%0d data=%h want nreq=1 data=%h", o_nreq, o_data, memval(32'h500)); end
    run_fetch(32'h0000_0100, 1'b1, 1, 1'b0);
    total++; if (o_nreq !== 1 || o_data !== 32'hA0) begin bad++; $display("FAIL conflict_reread: got nreq=%0d data=%h want nreq=1 data=000000a0", o_nreq, o_data); end
  endtask

  task automatic test_write();
    run_fetch(32'h0000_0104, 1'b0, 0, 1'b0);
    total++; if (o_nreq !== 0 || o_ready_cyc !== 2 || o_data !== 32'h0) begin bad++; $display("FAIL write_resp: got nreq=%0d cyc=%0d data=%h want nreq=0 cyc=2 data=0", o_nreq, o_ready_cyc, o_data); end
    run_fetch(32'h0000_0104, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 0 || o_data !== 32'hA1) begin bad++; $display("FAIL write_keep: got nreq=%0d data=%h want nreq=0 data=000000a1", o_nreq, o_data); end
    run_fetch(32'h0000_7000, 1'b0, 0, 1'b0);
    total++; if (o_nreq !== 0) begin bad++; $display("FAIL write_nomreq: got %0d want 0", o_nreq); end
    run_fetch(32'h0000_7000, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 1) begin bad++; $display("FAIL write_nofill: got nreq=%0d want 1", o_nreq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [5];
    seq[0] = 32'h100; seq[1] = 32'h104; seq[2] = 32'h108; seq[3] = 32'h10C; seq[4] = 32'h108;
    run_fetch(32'h100, 1'b1, 0, 1'b0);
    P_rw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      P_strobe = 1'b1; P_addr = seq[i];
      tick();
      total++; if (P_ready !== 1'b0) begin bad++; $display("FAIL b2b_gap%0d: got ready=%b want 0", i, P_ready); end
      tick();
      total++; if (P_ready !== 1'b1 || P_data !== memval(seq[i])) begin bad++; $display("FAIL b2b_resp%0d: got ready=%b data=%h want ready=1 data=%h", i, P_ready, P_data, memval(seq[i])); end
    end
    P_strobe = 1'b0;
    tick();
    total++; if (M_req !== 1'b0 && P_ready !== 1'b0) begin bad++; $display("FAIL b2b_tail: got mreq=%b ready=%b want 0", M_req, P_ready); end
  endtask

  task automatic test_flush_gap();
    run_fetch(32'h0000_3048, 1'b1, 2, 1'b1);
    total++; if (o_nreq !== 1 || o_data !== memval(32'h3048)) begin bad++; $display("FAIL flush_data: got nreq=%0d data=%h want nreq=1 data=%h", o_nreq, o_data, memval(32'h3048)); end
    total++; if (o_ready_cyc - o_last_cyc !== 2) begin bad++; $display("FAIL flush_latency: got %0d want 2", o_ready_cyc - o_last_cyc); end
    run_fetch(32'h0000_3048, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 1) begin bad++; $display("FAIL flush_invalid: got nreq=%0d want 1", o_nreq); end
  endtask

  task automatic test_reset_mid_refill();
    P_strobe = 1'b1; P_addr = 32'h0000_2000; P_rw = 1'b1;
    tick();
    P_strobe = 1'b0;
    tick();
    total++; if (M_req !== 1'b1) begin bad++; $display("FAIL rstmid_mreq: got %b want 1", M_req); end
    M_valid = 1'b1; M_data = memval(32'h2000);
    tick();
    M_data = memval(32'h2004);
    tick();
    rst = 1'b1; M_data = memval(32'h2008);
    tick();
    rst = 1'b0; M_data = memval(32'h200C);
    model_clear();
    total++; if (P_ready !== 1'b0 || P_data !== 32'h13 || M_req !== 1'b0 || M_addr !== 32'h0) begin bad++; $display("FAIL rstmid_outputs: got ready=%b data=%h mreq=%b maddr=%h want 0/00000013/0/0", P_ready, P_data, M_req, M_addr); end
    tick();
    M_valid = 1'b0;
    tick();
    total++; if (P_ready !== 1'b0) begin bad++; $display("FAIL rstmid_stray: got ready=%b want 0", P_ready); end
    run_fetch(32'h0000_2000, 1'b1, 0, 1'b0);
    total++; if (o_nreq !== 1 || o_data !== memval(32'h2000)) begin bad++; $display("FAIL rstmid_refetch: got nreq=%0d data=%h want nreq=1 data=%h", o_nreq, o_data, memval(32'h2000)); end
  endtask

  task automatic test_random();
    logic [31:0] addr, exp_data;
    logic        rw;
    int          gap, exp_nreq;
    bit          fl;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1; tick(); flush = 1'b0; model_clear();
      end
      addr = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      rw   = ($urandom_range(0, 9) != 0);
      gap  = int'($urandom_range(0, 2));
      fl   = ($urandom_range(0, 9) == 0);
      run_fetch(addr, rw, gap, fl);
      exp_data = rw ? memval(addr) : 32'h0;
      exp_nreq = (rw && !o_exp_hit) ? 1 : 0;
      total++; if (o_data !== exp_data) begin bad++; $display("FAIL rand%0d_data: addr=%h got %h want %h", n, addr, o_data, exp_data); end
      total++; if (o_nreq !== exp_nreq) begin bad++; $display("FAIL rand%0d_nreq: addr=%h got %0d want %0d", n, addr, o_nreq, exp_nreq); end
      if (exp_nreq == 1) begin
        total++; if (o_maddr !== (addr & ~32'hF) || o_ready_cyc - o_last_cyc !== 2) begin bad++; $display("FAIL rand%0d_refill: got maddr=%h lat=%0d want maddr=%h lat=2", n, o_maddr, o_ready_cyc - o_last_cyc, addr & ~32'hF); end
      end else begin
        total++; if (o_ready_cyc !== 2) begin bad++; $display("FAIL rand%0d_latency: got %0d want 2", n, o_ready_cyc); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; P_strobe = 1'b0; P_addr = '0; P_rw = 1'b1; flush = 1'b0; M_valid = 1'b0; M_data = '0;
    ovr[32'h100] = 32'hA0; ovr[32'h104] = 32'hA1; ovr[32'h108] = 32'hA2; ovr[32'h10C] = 32'hA3;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_write();
    test_back_to_back();
    test_flush_gap();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_core.md
# icache_core

Direct-mapped instruction cache core sitting directly downstream of the CPU-side instruction fetch front-end. It answers its P_ strobe/ready requests: a tag lookup, then either a hit response or a burst line refill from the memory bus (M_ side), then a response. It is read-only; instruction memory is never written through this block.

## Interface
- ADDR_W, 32, byte address width
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)
- NUM_LINES, 64, number of lines (power of 2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- P_strobe  in  1  fetch request, level; sampled only in IDLE
- P_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- P_rw  in  1  1 = read; 0 = write (no-op, see Operation)
- P_data  out  32  returned instruction word
- P_ready  out  1  one-cycle pulse; P_data valid this cycle
- flush  in  1  pulse; invalidate all lines
- M_req  out  1  one-cycle pulse requesting a line burst
- M_addr  out  ADDR_W  line-aligned burst address, held until burst ends
- M_data  in  32  burst beat data
- M_valid  in  1  beat valid; beats arrive in ascending word order, may have gaps

## Operation
- Address split: word = P_addr[2 +: log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- States: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE: P_strobe=1 → latch P_addr/P_rw into req_addr/req_rw → LOOKUP. Otherwise stay.
- LOOKUP, req_rw=0: P_data←0, P_ready←1 → IDLE. Arrays are not touched.
- LOOKUP, hit (valid[index] && tag match): P_data←data[index][word], P_ready←1 → IDLE.
- LOOKUP, miss: M_req←1 for one cycle, M_addr←{req tag, index, 0…}, beat_cnt←0 → REFILL.
- REFILL: each M_valid writes M_data into data[index][beat_cnt], beat_cnt+1. On beat LINE_WORDS-1: tag[index]←req tag, valid[index]←1 → RESPOND. M_valid in any other state is ignored.
- RESPOND: P_data←data[index][word], P_ready←1 → IDLE.
- P_data holds its last value when P_ready=0.
- flush clears every valid bit in the cycle it is high, in any state. It has priority over the valid set on the final refill beat, so that line ends invalid. The pending response still completes with the fetched word.
- A P_strobe that is still high in the P_ready cycle is sampled by IDLE as a new request. This allows back-to-back fetches.

## Timing
- Reset values: P_ready=0, P_data=32'h0000_0013 (NOP), M_req=0, M_addr=0, state=IDLE, beat_cnt=0, all valid=0. Tag and data arrays are not reset.
- Hit latency: strobe sampled in cycle n, P_ready in cycle n+2.
- Miss: M_req in cycle n+2. Final beat in cycle m gives P_ready in cycle m+2.
- Back-to-back hits: one response every 2 cycles.
- rst mid-refill: the burst is abandoned and no line becomes valid. The remaining beats arrive in IDLE and are ignored. The memory side must tolerate this.
- All outputs are registered. The tag/valid/data read in LOOKUP and RESPOND is combinational from flop arrays.

## Structure
- Package icache_pkg holds:
  - state enum
  - derived widths WORD_W, INDEX_W, TAG_W as functions of the parameters
  - NOP constant 32'h13
- Sub-module icache_store holds the valid, tag and data arrays:
  - one combinational read port
  - one word write port
  - one tag/valid write port
  - a flush-all input
- The FSM, beat counter and request registers live in icache_core.

## Test plan
- Cold miss: after reset, read 0x0000_0100; memory returns 0xA0..0xA3 with no gaps → one M_req, M_addr=0x100, P_ready 2 cycles after the last beat, P_data=0xA0.
- Hit: then read 0x0000_010C → P_ready in cycle n+2, P_data=0xA3, no M_req.
- Conflict: read 0x0000_0500 (same index, new tag) → refill. A re-read of 0x100 then misses again.
- Gapped burst plus flush: beats with 2-cycle gaps, flush on the final-beat cycle → P_data is still correct, and the next read of the same address misses.
- Write request: P_rw=0 → P_ready at n+2, P_data=0, no M_req, arrays unchanged (a subsequent hit returns the old data).
- Reset mid-refill: rst after beat 1, stray beats 2–3 arrive → outputs at reset values, the next read of that line misses.
